// File: rtl/snoop_cache_ctrl.sv
// MSI snooping cache controller: serves one sequencer request at a time from a
// direct-mapped cache, issues bus messages, and snoops other processors' traffic.
module snoop_cache_ctrl #(
    parameter int LINES   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [2:0] req_addr,
    input  logic [2:0] req_wdata,
    output logic       resp_valid,
    output logic [2:0] resp_data,
    output logic       bus_req,
    input  logic       bus_gnt,
    output logic [9:0] bus_out,
    input  logic [9:0] bus_in,
    input  logic       bus_in_valid,
    output logic       snoop_hit,
    output logic       snoop_out_valid,
    output logic [9:0] snoop_out
);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] CMD_DATA = 2'b00;
    localparam logic [1:0] CMD_WB   = 2'b01;
    localparam logic [1:0] CMD_RD   = 2'b10;
    localparam logic [1:0] CMD_WR   = 2'b11;

    typedef enum logic [1:0] {LINE_I = 2'd0, LINE_S = 2'd1, LINE_M = 2'd2} line_t;
    typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, ISSUE, FILL, RESP} state_t;

    state_t        state, state_nx;
    line_t         line_st   [LINES];
    logic          line_tag  [LINES];
    logic [2:0]    line_data [LINES];

    logic          wr_q;
    logic [2:0]    addr_q, wdata_q;
    logic [1:0]    cmd_q, cmd_nx;
    logic [CW-1:0] cnt;
    logic          own_q;

    logic [1:0]    idx, s_idx;
    logic [1:0]    in_cmd;
    logic [2:0]    in_addr, in_data;
    logic          msg_ok, hit, victim_m, evict_live, grant;
    logic          fill_match, snoop_ev, snoop_match, snoop_wb;

    assign idx     = addr_q[1:0];
    assign in_cmd  = bus_in[7:6];
    assign in_addr = bus_in[5:3];
    assign in_data = bus_in[2:0];
    assign s_idx   = in_addr[1:0];

    // Frames with a non-zero pad field are not well-formed messages and are ignored.
    assign msg_ok      = bus_in_valid && (bus_in[9:8] == 2'b00);
    assign hit         = (line_st[idx] != LINE_I) && (line_tag[idx] == addr_q[2]);
    assign victim_m    = (line_st[idx] == LINE_M) && (line_tag[idx] != addr_q[2]);
    // A snoop that already wrote the victim back leaves nothing to evict.
    assign evict_live  = (state == EVICT) && (line_st[idx] == LINE_M);
    assign grant       = bus_req && bus_gnt;
    // Only one message per cycle, so data reply (00) and write-back (01) never collide.
    assign fill_match  = msg_ok && !in_cmd[1] && (in_addr == addr_q);
    // The cycle after our own grant carries our own message and must not be snooped.
    assign snoop_ev    = msg_ok && !own_q && in_cmd[1];
    assign snoop_match = snoop_ev && (line_tag[s_idx] == in_addr[2]) && (line_st[s_idx] != LINE_I);
    assign snoop_wb    = snoop_match && (line_st[s_idx] == LINE_M);

    always_comb begin
        state_nx = state;
        cmd_nx   = cmd_q;
        case (state)
            IDLE:   if (req_valid) state_nx = LOOKUP;
            LOOKUP: begin
                if (hit && (!wr_q || line_st[idx] == LINE_M)) begin
                    state_nx = RESP;
                end else if (hit) begin
                    state_nx = ISSUE;
                    cmd_nx   = CMD_WR;
                end else begin
                    state_nx = victim_m ? EVICT : ISSUE;
                    cmd_nx   = wr_q ? CMD_WR : CMD_RD;
                end
            end
            EVICT:  if (!evict_live || bus_gnt) state_nx = ISSUE;
            ISSUE:  if (bus_gnt) state_nx = (cmd_q == CMD_WR) ? RESP : FILL;
            FILL: begin
                if (fill_match)                     state_nx = RESP;
                else if (cnt == CW'(TIMEOUT - 1))   state_nx = ISSUE;
            end
            RESP:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        resp_data  = (state == RESP) ? line_data[idx] : 3'b000;
        bus_req    = evict_live || (state == ISSUE);
        bus_out    = '0;
        if (evict_live)
            bus_out = {2'b00, CMD_WB, line_tag[idx], idx, line_data[idx]};
        else if (state == ISSUE)
            bus_out = {2'b00, cmd_q, addr_q, (cmd_q == CMD_WR) ? wdata_q : 3'b000};
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state           <= IDLE;
            cmd_q           <= CMD_DATA;
            cnt             <= '0;
            own_q           <= 1'b0;
            wr_q            <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            snoop_hit       <= 1'b0;
            snoop_out_valid <= 1'b0;
            snoop_out       <= '0;
            for (int i = 0; i < LINES; i++) begin
                line_st[i]   <= LINE_I;
                line_tag[i]  <= 1'b0;
                line_data[i] <= '0;
            end
        end else begin
            state           <= state_nx;
            cmd_q           <= cmd_nx;
            own_q           <= grant;
            snoop_out_valid <= snoop_wb;
            snoop_out       <= snoop_wb ? {2'b00, CMD_WB, in_addr, line_data[s_idx]} : '0;
            if (snoop_ev) snoop_hit <= snoop_match;
            if (snoop_match) begin
                if (in_cmd == CMD_WR)                line_st[s_idx] <= LINE_I;
                else if (line_st[s_idx] == LINE_M)   line_st[s_idx] <= LINE_S;
            end

            // Local updates come after the snoop update so they win on the same line.
            case (state)
                IDLE: if (req_valid) begin
                    wr_q    <= req_write;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                end
                LOOKUP: if (hit && wr_q && line_st[idx] == LINE_M) begin
                    line_st[idx]   <= LINE_M;
                    line_data[idx] <= wdata_q;
                end
                EVICT: if (grant) line_st[idx] <= LINE_I;
                ISSUE: if (bus_gnt) begin
                    if (cmd_q == CMD_WR) begin
                        line_st[idx]   <= LINE_M;
                        line_tag[idx]  <= addr_q[2];
                        line_data[idx] <= wdata_q;
                    end else begin
                        cnt <= '0;
                    end
                end
                FILL: begin
                    if (fill_match) begin
                        line_st[idx]   <= LINE_S;
                        line_tag[idx]  <= addr_q[2];
                        line_data[idx] <= in_data;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_snoop_cache_ctrl.sv
// Directed bench for snoop_cache_ctrl: a request table plus hand-written snoop,
// eviction, timeout and clear sequences, with a response scoreboard.
module tb_snoop_cache_ctrl;
    logic       clock = 1'b0;
    logic       clear;
    logic       req_valid, req_write;
    logic [2:0] req_addr, req_wdata;
    logic       req_ready, resp_valid;
    logic [2:0] resp_data;
    logic       bus_req, bus_gnt;
    logic [9:0] bus_out, bus_in;
    logic       bus_in_valid;
    logic       snoop_hit, snoop_out_valid;
    logic [9:0] snoop_out;

    int n_cmp = 0;
    int n_err = 0;
    logic [2:0] exp_q[$];

    snoop_cache_ctrl #(.LINES(4), .TIMEOUT(15)) dut (
        .clock(clock), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_out(bus_out),
        .bus_in(bus_in), .bus_in_valid(bus_in_valid),
        .snoop_hit(snoop_hit), .snoop_out_valid(snoop_out_valid), .snoop_out(snoop_out)
    );

    // clock / reset
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    // scoreboard: every response must match the head of the expected queue
    always @(negedge clock) begin
        if (resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_resp: got resp_data %b, required no response", resp_data);
            end else begin
                check("resp_data", {7'b0, resp_data}, {7'b0, exp_q.pop_front()});
            end
        end
    end

    // driver tasks (all driving happens on the falling edge)
    task automatic issue_req(input logic w, input logic [2:0] a, input logic [2:0] d);
        int k = 0;
        while (req_ready !== 1'b1 && k < 40) begin
            @(negedge clock);
            k++;
        end
        check("req_ready_before_req", {9'b0, req_ready}, 10'd1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic send(input logic [9:0] m);
        bus_in       = m;
        bus_in_valid = 1'b1;
        @(negedge clock);
        bus_in_valid = 1'b0;
        bus_in       = '0;
    endtask

    // wait for a bus request, check it, grant it, then echo it back on bus_in
    task automatic wait_bus(input string name, input logic [9:0] exp);
        int k = 0;
        while (bus_req !== 1'b1 && k < 40) begin
            @(negedge clock);
            k++;
        end
        check({name, "_bus_req"}, {9'b0, bus_req}, 10'd1);
        check(name, bus_out, exp);
        bus_gnt = 1'b1;
        @(negedge clock);
        bus_gnt = 1'b0;
        send(exp);
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 60) begin
            @(negedge clock);
            k++;
        end
        check({name, "_resp_seen"}, {9'b0, exp_q.size() == 0}, 10'd1);
        exp_q.delete();
    endtask

    task automatic run_req(input string name, input logic w, input logic [2:0] a,
                           input logic [2:0] d, input logic miss, input logic [9:0] bmsg,
                           input logic fill, input logic [9:0] reply, input logic [2:0] resp);
        exp_q.push_back(resp);
        issue_req(w, a, d);
        if (!miss) begin
            check({name, "_lookup_bus_req"}, {9'b0, bus_req}, 10'd0);
            check({name, "_lookup_resp"}, {9'b0, resp_valid}, 10'd0);
            @(negedge clock);
            check({name, "_cycle2_resp"}, {9'b0, resp_valid}, 10'd1);
            check({name, "_cycle2_bus_req"}, {9'b0, bus_req}, 10'd0);
        end else begin
            wait_bus({name, "_msg"}, bmsg);
            if (fill) send(reply);
        end
        wait_done(name);
    endtask

    typedef struct {
        logic       w;
        logic [2:0] a;
        logic [2:0] d;
        logic       miss;
        logic [9:0] bmsg;
        logic       fill;
        logic [9:0] reply;
        logic [2:0] resp;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int quiet;
        vecs[0] = '{1'b0, 3'b010, 3'b000, 1'b1, 10'b00_10_010_000, 1'b1, 10'b00_00_010_001, 3'b001};
        vecs[1] = '{1'b0, 3'b010, 3'b000, 1'b0, 10'b0,             1'b0, 10'b0,             3'b001};
        vecs[2] = '{1'b1, 3'b010, 3'b110, 1'b1, 10'b00_11_010_110, 1'b0, 10'b0,             3'b110};
        vecs[3] = '{1'b0, 3'b010, 3'b000, 1'b0, 10'b0,             1'b0, 10'b0,             3'b110};
        vecs[4] = '{1'b1, 3'b001, 3'b011, 1'b1, 10'b00_11_001_011, 1'b0, 10'b0,             3'b011};
        vecs[5] = '{1'b1, 3'b001, 3'b101, 1'b0, 10'b0,             1'b0, 10'b0,             3'b101};
        vecs[6] = '{1'b0, 3'b011, 3'b000, 1'b1, 10'b00_10_011_000, 1'b1, 10'b00_00_011_111, 3'b111};

        clear = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        bus_gnt = 1'b0; bus_in = '0; bus_in_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_req_ready", {9'b0, req_ready}, 10'd1);
        check("rst_resp_valid", {9'b0, resp_valid}, 10'd0);
        check("rst_bus_req", {9'b0, bus_req}, 10'd0);
        check("rst_snoop_hit", {9'b0, snoop_hit}, 10'd0);
        check("rst_snoop_out_valid", {9'b0, snoop_out_valid}, 10'd0);
        check("rst_bus_out", bus_out, 10'd0);
        check("rst_snoop_out", snoop_out, 10'd0);
        check("rst_resp_data", {7'b0, resp_data}, 10'd0);
        clear = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 7; i++)
            run_req($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].miss,
                    vecs[i].bmsg, vecs[i].fill, vecs[i].reply, vecs[i].resp);

        // snoops against 010=M(110), 001=M(101)
        send(10'b00_10_010_000);
        check("snp_rd_m_hit", {9'b0, snoop_hit}, 10'd1);
        check("snp_rd_m_valid", {9'b0, snoop_out_valid}, 10'd1);
        check("snp_rd_m_msg", snoop_out, 10'b00_01_010_110);
        @(negedge clock);
        check("snp_rd_m_one_cycle", {9'b0, snoop_out_valid}, 10'd0);
        run_req("read_after_downgrade", 1'b0, 3'b010, 3'b000, 1'b0, 10'b0, 1'b0, 10'b0, 3'b110);
        send(10'b00_10_110_000);
        check("snp_tag_miss_hit", {9'b0, snoop_hit}, 10'd0);
        check("snp_tag_miss_valid", {9'b0, snoop_out_valid}, 10'd0);
        send(10'b00_11_010_000);
        check("snp_wr_s_hit", {9'b0, snoop_hit}, 10'd1);
        check("snp_wr_s_valid", {9'b0, snoop_out_valid}, 10'd0);
        send(10'b00_11_001_000);
        check("snp_wr_m_valid", {9'b0, snoop_out_valid}, 10'd1);
        check("snp_wr_m_msg", snoop_out, 10'b00_01_001_101);
        run_req("read_after_inval", 1'b0, 3'b010, 3'b000, 1'b1, 10'b00_10_010_000,
                1'b1, 10'b00_00_010_100, 3'b100);

        // eviction of a modified victim
        run_req("write_s_010", 1'b1, 3'b010, 3'b110, 1'b1, 10'b00_11_010_110, 1'b0, 10'b0, 3'b110);
        exp_q.push_back(3'b010);
        issue_req(1'b0, 3'b110, 3'b000);
        wait_bus("evict_msg", 10'b00_01_010_110);
        wait_bus("evict_then_rd", 10'b00_10_110_000);
        send(10'b00_00_110_010);
        wait_done("evict_read");

        // snoop write-back supersedes a pending eviction
        run_req("write_s_110", 1'b1, 3'b110, 3'b011, 1'b1, 10'b00_11_110_011, 1'b0, 10'b0, 3'b011);
        exp_q.push_back(3'b110);
        issue_req(1'b0, 3'b010, 3'b000);
        @(negedge clock);
        check("race_evict_req", {9'b0, bus_req}, 10'd1);
        check("race_evict_msg", bus_out, 10'b00_01_110_011);
        send(10'b00_10_110_000);
        check("race_snoop_wb", snoop_out, 10'b00_01_110_011);
        check("race_evict_dropped", {9'b0, bus_req}, 10'd0);
        wait_bus("race_rd", 10'b00_10_010_000);
        send(10'b00_00_010_110);
        wait_done("race_read");

        // fill timeout and re-issue, answered by a write-back
        exp_q.push_back(3'b101);
        issue_req(1'b0, 3'b111, 3'b000);
        wait_bus("to_first", 10'b00_10_111_000);
        quiet = 0;
        for (int i = 0; i < 14; i++) begin
            if (bus_req === 1'b0) quiet++;
            @(negedge clock);
        end
        check("to_quiet_cycles", 10'(quiet), 10'd14);
        check("to_reissue_req", {9'b0, bus_req}, 10'd1);
        wait_bus("to_reissue", 10'b00_10_111_000);
        send(10'b00_01_111_101);
        wait_done("timeout_read");

        // clear in the middle of a fill
        issue_req(1'b0, 3'b101, 3'b000);
        wait_bus("clr_rd", 10'b00_10_101_000);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        check("clr_req_ready", {9'b0, req_ready}, 10'd1);
        check("clr_bus_req", {9'b0, bus_req}, 10'd0);
        check("clr_resp_valid", {9'b0, resp_valid}, 10'd0);
        check("clr_snoop_hit", {9'b0, snoop_hit}, 10'd0);
        send(10'b00_00_101_001);
        repeat (3) @(negedge clock);
        run_req("read_after_clear", 1'b0, 3'b111, 3'b000, 1'b1, 10'b00_10_111_000,
                1'b1, 10'b00_00_111_011, 3'b011);
        repeat (2) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
